// File: rtl/proc_multicycle_core_pkg.sv
// Shared constants for the multi-cycle AR/T core: opcodes, ALU function
// codes, FSM state encoding and instruction field positions.
package proc_multicycle_core_pkg;

    // Opcodes (instruction bits [31:27])
    localparam logic [4:0] OP_AR   = 5'h00;
    localparam logic [4:0] OP_T    = 5'h01;
    localparam logic [4:0] OP_BZ   = 5'h02;
    localparam logic [4:0] OP_HALT = 5'h1F;

    // ALU function codes (instruction bits [26:23]); 8..15 yield zero
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SLT = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;

    // Sequencer states; HALT is terminal until reset
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Field positions. T and BZ reuse the rs1 slot as rd/rs1 and carry a
    // 19-bit signed immediate in the low bits.
    localparam int OP_LO  = 27;
    localparam int FN_LO  = 23;
    localparam int RS1_LO = 19;
    localparam int RS2_LO = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_W  = 19;

    function automatic logic [4:0] f_op(input logic [31:0] ir);
        return ir[OP_LO +: 5];
    endfunction

    function automatic logic [3:0] f_func(input logic [31:0] ir);
        return ir[FN_LO +: 4];
    endfunction

endpackage

// File: rtl/proc_multicycle_core_regfile.sv
// Register file: NUM_REGS x DATA_W, two combinational read ports, one
// synchronous write port, whole array cleared by reset.
module proc_multicycle_core_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_raddr_a,
    input  logic [3:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [3:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Write port; reset clears every register so no stale value survives
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/proc_multicycle_core.sv
// Multi-cycle AR/T core: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH,
// with a req/ready instruction fetch port and a one-cycle writeback trace.
module proc_multicycle_core
    import proc_multicycle_core_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PC_W-1:0]   i_start_pc,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [31:0]       i_imem_rdata,
    output logic              o_halted,
    output logic              o_illegal,
    output logic              o_wb_valid,
    output logic [3:0]        o_wb_reg,
    output logic [DATA_W-1:0] o_wb_data
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;
    logic              r_taken;
    logic              r_imem_req;
    logic              r_halted;
    logic              r_illegal;
    logic              r_wb_valid;
    logic [3:0]        r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;

    logic [4:0]        w_op;
    logic [3:0]        w_func;
    logic [3:0]        w_rs1;
    logic [3:0]        w_rs2;
    logic [3:0]        w_rd;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] w_imm_ext;
    logic [5:0]        w_shamt;
    logic              w_shamt_ovf;
    logic [DATA_W-1:0] w_alu;

    assign w_op      = f_op(r_ir);
    assign w_func    = f_func(r_ir);
    assign w_rs1     = r_ir[RS1_LO +: 4];
    assign w_rs2     = r_ir[RS2_LO +: 4];
    assign w_rd      = r_ir[RD_LO +: 4];
    assign w_imm_ext = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
    assign w_shamt   = r_b[5:0];
    assign w_shamt_ovf = (int'(w_shamt) >= DATA_W);

    // Writeback goes to the register file during the WB cycle, so the next
    // DECODE already sees the new value.
    proc_multicycle_core_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_raddr_a (w_rs1),
        .i_raddr_b (w_rs2),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b),
        .i_we      (r_wb_valid),
        .i_waddr   (r_wb_reg),
        .i_wdata   (r_wb_data)
    );

    // ALU on the operand latches captured in DECODE
    always_comb begin
        w_alu = '0;
        case (w_func)
            FN_ADD:  w_alu = r_a + r_b;
            FN_SUB:  w_alu = r_a - r_b;
            FN_AND:  w_alu = r_a & r_b;
            FN_OR:   w_alu = r_a | r_b;
            FN_XOR:  w_alu = r_a ^ r_b;
            FN_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            FN_SLL:  w_alu = w_shamt_ovf ? '0 : (r_a << w_shamt);
            FN_SRL:  w_alu = w_shamt_ovf ? '0 : (r_a >> w_shamt);
            default: w_alu = '0;
        endcase
    end

    // Instruction sequencer with registered handshake and trace outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_taken    <= 1'b0;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pc       <= i_start_pc;
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    // Address and request stay put until memory answers
                    if (i_imem_ready) begin
                        r_ir       <= i_imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_a     <= w_rdata_a;
                    r_b     <= w_rdata_b;
                    r_imm   <= w_imm_ext;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (w_op)
                        OP_AR: begin
                            r_wb_valid <= 1'b1;
                            r_wb_reg   <= w_rd;
                            r_wb_data  <= w_alu;
                            r_state    <= ST_WB;
                        end
                        OP_T: begin
                            r_wb_valid <= 1'b1;
                            r_wb_reg   <= w_rs1;
                            r_wb_data  <= r_imm;
                            r_state    <= ST_WB;
                        end
                        OP_BZ: begin
                            r_taken <= (r_a == '0);
                            r_state <= ST_WB;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                        default: begin
                            r_halted  <= 1'b1;
                            r_illegal <= 1'b1;
                            r_state   <= ST_HALT;
                        end
                    endcase
                end
                ST_WB: begin
                    r_wb_valid <= 1'b0;
                    if ((w_op == OP_BZ) && r_taken) begin
                        r_pc <= r_pc + r_imm[PC_W-1:0];
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_pc;
    assign o_halted    = r_halted;
    assign o_illegal   = r_illegal;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_reg    = r_wb_reg;
    assign o_wb_data   = r_wb_data;

endmodule

// File: tb/tb_proc_multicycle_core.sv
// Bench for proc_multicycle_core: directed programs plus random instruction
// streams checked against an instruction-level reference model.
module tb_proc_multicycle_core;

    localparam int DW = 32;
    localparam int PW = 16;
    localparam logic [PW-1:0] START_PC = 16'h0010;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [PW-1:0] i_start_pc = START_PC;
    logic          o_imem_req;
    logic [PW-1:0] o_imem_addr;
    logic          i_imem_ready = 1'b0;
    logic [31:0]   i_imem_rdata = '0;
    logic          o_halted;
    logic          o_illegal;
    logic          o_wb_valid;
    logic [3:0]    o_wb_reg;
    logic [DW-1:0] o_wb_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference architectural state
    logic [31:0]   m_r [16];
    logic [PW-1:0] m_pc;

    proc_multicycle_core #(.DATA_W(DW), .PC_W(PW), .NUM_REGS(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start_pc   (i_start_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ready (i_imem_ready),
        .i_imem_rdata (i_imem_rdata),
        .o_halted     (o_halted),
        .o_illegal    (o_illegal),
        .o_wb_valid   (o_wb_valid),
        .o_wb_reg     (o_wb_reg),
        .o_wb_data    (o_wb_data)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ar(input int fn, input int rs1, input int rs2, input int rd);
        logic [31:0] w;
        w = '0;
        w[26:23] = 4'(fn);
        w[22:19] = 4'(rs1);
        w[18:15] = 4'(rs2);
        w[14:11] = 4'(rd);
        return w;
    endfunction

    function automatic logic [31:0] mk_imm(input logic [4:0] op, input int r, input int imm);
        logic [31:0] w;
        logic [31:0] v;
        v = 32'(imm);
        w = '0;
        w[31:27] = op;
        w[22:19] = 4'(r);
        w[18:0]  = v[18:0];
        return w;
    endfunction

    function automatic logic [31:0] alu_ref(input int fn, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 64;
        case (fn)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return (sh >= 32) ? 32'd0 : (a << sh);
            7: return (sh >= 32) ? 32'd0 : (a >> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Architectural effect of one instruction on the reference state
    task automatic model(input logic [31:0] ins, output bit wb, output logic [3:0] rg,
                         output logic [31:0] dat, output bit hlt, output bit ill);
        logic [4:0]  op;
        logic [31:0] a, b, imm;
        op  = ins[31:27];
        a   = m_r[ins[22:19]];
        b   = m_r[ins[18:15]];
        imm = {{13{ins[18]}}, ins[18:0]};
        wb = 0; rg = '0; dat = '0; hlt = 0; ill = 0;
        if (op == 5'h00) begin
            rg = ins[14:11]; dat = alu_ref(int'(ins[26:23]), a, b); wb = 1;
            m_r[rg] = dat; m_pc = m_pc + 1'b1;
        end else if (op == 5'h01) begin
            rg = ins[22:19]; dat = imm; wb = 1;
            m_r[rg] = dat; m_pc = m_pc + 1'b1;
        end else if (op == 5'h02) begin
            m_pc = (a == 0) ? m_pc + imm[PW-1:0] : m_pc + 1'b1;
        end else if (op == 5'h1F) begin
            hlt = 1;
        end else begin
            hlt = 1; ill = 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = START_PC;
    endtask

    // Serve one instruction with `waits` not-ready cycles and check everything
    task automatic step(input logic [31:0] ins, input int waits);
        bit ewb, ehlt, eill;
        logic [3:0] erg;
        logic [31:0] edat;
        logic [PW-1:0] pc0;
        int c0, n;
        pc0 = m_pc;
        n = 0;
        while (o_imem_req !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("fetch_req", 64'(o_imem_req), 64'd1);
        chk("fetch_addr", 64'(o_imem_addr), 64'(pc0));
        c0 = cyc;
        for (int w = 0; w < waits; w++) begin
            i_imem_ready = 1'b0;
            i_imem_rdata = $urandom;
            @(negedge i_clk);
            chk("wait_req", 64'(o_imem_req), 64'd1);
            chk("wait_addr", 64'(o_imem_addr), 64'(pc0));
        end
        i_imem_ready = 1'b1;
        i_imem_rdata = ins;
        @(negedge i_clk);
        // Ready toggles outside FETCH must be ignored
        i_imem_ready = 1'($urandom_range(0, 1));
        i_imem_rdata = $urandom;
        model(ins, ewb, erg, edat, ehlt, eill);
        chk("dec_req", 64'(o_imem_req), 64'd0);
        chk("dec_wb", 64'(o_wb_valid), 64'd0);
        @(negedge i_clk);
        chk("exec_wb", 64'(o_wb_valid), 64'd0);
        @(negedge i_clk);
        chk("wb_valid", 64'(o_wb_valid), 64'(ewb));
        if (ewb) begin
            chk("wb_reg", 64'(o_wb_reg), 64'(erg));
            chk("wb_data", 64'(o_wb_data), 64'(edat));
        end
        chk("halted", 64'(o_halted), 64'(ehlt));
        chk("illegal", 64'(o_illegal), 64'(eill));
        @(negedge i_clk);
        i_imem_ready = 1'b0;
        chk("wb_pulse", 64'(o_wb_valid), 64'd0);
        if (!ehlt) begin
            chk("next_req", 64'(o_imem_req), 64'd1);
            chk("next_addr", 64'(o_imem_addr), 64'(m_pc));
            chk("latency", 64'(cyc - c0), 64'(4 + waits));
        end else begin
            chk("halt_req", 64'(o_imem_req), 64'd0);
        end
        $display("[TB] pc=%04h ins=%08h waits=%0d wb=%0b r%0d=%08h halt=%0b ill=%0b next=%04h",
                 pc0, ins, waits, ewb, erg, edat, ehlt, eill, m_pc);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_imem_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_req", 64'(o_imem_req), 64'd0);
        chk("rst_addr", 64'(o_imem_addr), 64'd0);
        chk("rst_halted", 64'(o_halted), 64'd0);
        chk("rst_illegal", 64'(o_illegal), 64'd0);
        chk("rst_wb_valid", 64'(o_wb_valid), 64'd0);
        chk("rst_wb_reg", 64'(o_wb_reg), 64'd0);
        chk("rst_wb_data", 64'(o_wb_data), 64'd0);
        model_reset();
        i_rst = 1'b0;
    endtask

    initial begin
        int kind;
        logic [31:0] ins;

        do_reset();

        // Constants, arithmetic and signed compare
        step(mk_imm(5'h01, 1, 5), 0);
        step(mk_imm(5'h01, 2, -3), 0);
        chk("t_neg_const", 64'(o_wb_data), 64'hFFFF_FFFD);
        step(mk_ar(0, 1, 2, 3), 0);
        chk("add_const", 64'(o_wb_data), 64'd2);
        step(mk_ar(5, 2, 1, 4), 0);
        chk("slt_const", 64'(o_wb_data), 64'd1);
        // Stalled fetch: three not-ready cycles
        step(mk_imm(5'h01, 5, 0), 3);
        // Branches: taken forward to 0x20, taken backward, not taken
        step(mk_imm(5'h02, 5, 11), 0);
        step(mk_imm(5'h02, 5, -2), 0);
        step(mk_imm(5'h02, 1, -2), 0);
        step(mk_imm(5'h02, 1, 7), 1);
        // Shift boundaries, wrap-around and rd==rs
        step(mk_imm(5'h01, 6, 40), 0);
        step(mk_ar(6, 1, 6, 7), 0);
        step(mk_imm(5'h01, 6, 31), 0);
        step(mk_ar(7, 2, 6, 7), 0);
        step(mk_imm(5'h01, 8, -1), 0);
        step(mk_ar(0, 8, 1, 8), 2);
        step(mk_ar(1, 5, 1, 15), 0);
        step(mk_ar(9, 1, 2, 9), 0);

        // Random instruction stream
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)
                ins = mk_ar($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15));
            else if (kind <= 8)
                ins = mk_imm(5'h01, $urandom_range(0, 15), int'($urandom));
            else
                ins = mk_imm(5'h02, $urandom_range(0, 15), $urandom_range(0, 15) - 8);
            step(ins, $urandom_range(0, 2));
        end

        // HALT is terminal and not illegal
        step(32'hF800_0000, 0);
        for (int k = 0; k < 5; k++) begin
            i_imem_ready = 1'b1;
            @(negedge i_clk);
            chk("halt_stay_req", 64'(o_imem_req), 64'd0);
            chk("halt_stay_h", 64'(o_halted), 64'd1);
            chk("halt_stay_wb", 64'(o_wb_valid), 64'd0);
        end

        // Undefined opcode halts and flags illegal
        do_reset();
        step(mk_imm(5'h07, 3, 1), 0);
        @(negedge i_clk);
        chk("ill_sticky", 64'(o_illegal), 64'd1);
        chk("ill_req", 64'(o_imem_req), 64'd0);

        // Reset during EXEC of an AR aborts the write
        do_reset();
        step(mk_imm(5'h01, 1, 7), 0);
        step(mk_imm(5'h01, 2, 9), 0);
        while (o_imem_req !== 1'b1) @(negedge i_clk);
        i_imem_ready = 1'b1;
        i_imem_rdata = mk_ar(0, 1, 2, 3);
        @(negedge i_clk);
        i_imem_ready = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("abort_wb", 64'(o_wb_valid), 64'd0);
        chk("abort_addr", 64'(o_imem_addr), 64'd0);
        @(negedge i_clk);
        chk("abort_wb2", 64'(o_wb_valid), 64'd0);
        model_reset();
        i_rst = 1'b0;
        step(mk_ar(0, 1, 2, 3), 0);
        chk("abort_regs0", 64'(o_wb_data), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
